rocev2_top_hls_deadlock_report_unit: RTL and testbench

Central controller on the far side of the per-process deadlock detect units in the rocev2 HLS dataflow top. It watches every unit's deadlock flag, elects one origin process, broadcasts detect mode, follows the report token around the dependency cycle and records which processes it visits. It then issues token clear and streams the recorded cycle out as a list of process IDs over a valid/ready handshake for debug readout.

---
 rtl/rocev2_top_hls_deadlock_report_unit.sv | 209 ++++++++++++++++++++
 tb/tb_rocev2_top_hls_deadlock_report_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocev2_top_hls_deadlock_report_unit.sv
// rocev2_top_hls_deadlock_report_unit
//
// Central deadlock report controller for the rocev2 HLS dataflow top.
// It watches the per-process deadlock flags and elects the lowest-numbered
// flagged process as origin. It then broadcasts detect mode and follows the
// report token around the dependency cycle, recording each distinct process
// it visits. Finally it streams the cycle (origin first) out over a
// valid/ready handshake.
//
// Optional feature macro: ROCEV2_DL_REPORT_TIMEOUT_EN
//   When defined, WAIT_TOKEN gives up after TIMEOUT consecutive cycles with
//   no token holder. It clears the token, flushes the path and returns to
//   IDLE. When undefined, WAIT_TOKEN waits indefinitely.

module rocev2_top_hls_deadlock_report_unit #(
    parameter int PROC_NUM = 4,
    parameter int ID_WIDTH = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_vec,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [ID_WIDTH-1:0] rpt_proc_id,
    output logic                rpt_last,
    output logic                rpt_trunc,
    output logic                dl_found,
    output logic                busy
);

    // Path buffer holds everything but the origin, so it is one entry short
    // of the process count.
    localparam int                DEPTH     = PROC_NUM - 1;
    localparam logic [ID_WIDTH-1:0] LAST_SLOT = ID_WIDTH'(DEPTH);

    // Reject configurations that cannot represent every process ID.
    if (PROC_NUM < 2 || (1 << ID_WIDTH) < PROC_NUM || TIMEOUT < 1) begin : g_bad_params
        $error("rocev2_top_hls_deadlock_report_unit: invalid parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_TOKEN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] org_id;
    logic [ID_WIDTH-1:0] count;      // entries held in the path buffer
    logic [ID_WIDTH-1:0] last_id;    // most recently pushed ID (valid when count != 0)
    logic [ID_WIDTH-1:0] rd_idx;     // next buffer entry to present in REPORT
    logic [ID_WIDTH-1:0] path_buf [DEPTH];

    logic [ID_WIDTH-1:0] hold_id;
    logic                tok_any;
    logic                in_wait;
    logic                do_push;
    logic                buf_full;
    logic                push_ok;
    logic                overflow;
    logic                origin_det;
    logic [ID_WIDTH-1:0] next_count;

`ifdef ROCEV2_DL_REPORT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            timeout_fire;
`endif

    // Index of the lowest set bit; the lowest-numbered process wins ties.
    function automatic logic [ID_WIDTH-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
        lowest_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_WIDTH'(i);
        end
    endfunction

    // Token tracking decisions for the current WAIT_TOKEN cycle.
    always_comb begin
        hold_id    = lowest_idx(token_vec);
        tok_any    = |token_vec;
        in_wait    = (state == S_WAIT_TOKEN);
        // Skip the origin itself and repeats of the holder we just recorded.
        do_push    = in_wait && tok_any && (hold_id != org_id) &&
                     !((count != '0) && (hold_id == last_id));
        buf_full   = (count == LAST_SLOT);
        push_ok    = do_push && !buf_full;
        overflow   = do_push && buf_full;
        origin_det = in_wait && dl_detect_vec[org_id];
        next_count = count + ID_WIDTH'(push_ok);
`ifdef ROCEV2_DL_REPORT_TIMEOUT_EN
        timeout_fire = in_wait && !tok_any && !origin_det &&
                       (idle_cnt == TO_W'(TIMEOUT - 1));
        // NOTE: token_clear is deliberately combinational so the clear lands in
        // the very cycle the origin reports detection, not one cycle late.
        token_clear  = origin_det || timeout_fire;
`else
        token_clear  = origin_det;
`endif
    end

    // Path storage: written in push order, read back during REPORT.
    // NOTE: the buffer array has no reset; count alone defines which entries
    // are valid, so clearing the storage would only cost flops and routing.
    always_ff @(posedge clock) begin
        if (push_ok) path_buf[count] <= hold_id;
    end

    // Main controller FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            org_id       <= '0;
            count        <= '0;
            last_id      <= '0;
            rd_idx       <= '0;
            dl_detect_in <= 1'b0;
            origin       <= '0;
            rpt_valid    <= 1'b0;
            rpt_proc_id  <= '0;
            rpt_last     <= 1'b0;
            rpt_trunc    <= 1'b0;
            dl_found     <= 1'b0;
            busy         <= 1'b0;
`ifdef ROCEV2_DL_REPORT_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|dl_detect_vec) begin
                        org_id       <= lowest_idx(dl_detect_vec);
                        origin       <= PROC_NUM'(1) << lowest_idx(dl_detect_vec);
                        dl_detect_in <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_ARM;
                    end
                end

                S_ARM: begin
                    origin <= '0;
                    count  <= '0;
                    rd_idx <= '0;
`ifdef ROCEV2_DL_REPORT_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    state  <= S_WAIT_TOKEN;
                end

                S_WAIT_TOKEN: begin
                    if (push_ok) begin
                        count   <= next_count;
                        last_id <= hold_id;
                    end
                    if (origin_det || overflow) begin
                        rpt_valid   <= 1'b1;
                        rpt_proc_id <= org_id;
                        rpt_last    <= (next_count == '0);
                        rpt_trunc   <= overflow;
                        state       <= S_REPORT;
                    end
`ifdef ROCEV2_DL_REPORT_TIMEOUT_EN
                    else if (timeout_fire) begin
                        dl_detect_in <= 1'b0;
                        busy         <= 1'b0;
                        count        <= '0;
                        state        <= S_IDLE;
                    end else if (tok_any) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end

                S_REPORT: begin
                    if (rpt_ready) begin
                        if (rpt_last) begin
                            rpt_valid   <= 1'b0;
                            rpt_proc_id <= '0;
                            rpt_last    <= 1'b0;
                            rpt_trunc   <= 1'b0;
                            dl_found    <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            rpt_proc_id <= path_buf[rd_idx];
                            rpt_last    <= (rd_idx == count - 1'b1);
                            rd_idx      <= rd_idx + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Terminal until reset; detect mode stays asserted.
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rocev2_top_hls_deadlock_report_unit.sv
// Self-checking bench for rocev2_top_hls_deadlock_report_unit (PROC_NUM=4).
// Table-driven main path plus hand-written stall, overflow, empty-path,
// reset and (macro-gated) timeout sequences.

module tb_rocev2_top_hls_deadlock_report_unit;

    logic       clock;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic [3:0] token_vec;
    logic       dl_detect_in;
    logic [3:0] origin;
    logic       token_clear;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [1:0] rpt_proc_id;
    logic       rpt_last;
    logic       rpt_trunc;
    logic       dl_found;
    logic       busy;

    int total = 0;
    int bad   = 0;

    rocev2_top_hls_deadlock_report_unit #(
        .PROC_NUM(4),
        .ID_WIDTH(2),
        .TIMEOUT (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dl_detect_vec(dl_detect_vec),
        .token_vec    (token_vec),
        .dl_detect_in (dl_detect_in),
        .origin       (origin),
        .token_clear  (token_clear),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_proc_id  (rpt_proc_id),
        .rpt_last     (rpt_last),
        .rpt_trunc    (rpt_trunc),
        .dl_found     (dl_found),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] det;
        logic [3:0] tok;
        logic       rdy;
        logic       dli;
        logic [3:0] org;
        logic       tc;
        logic       vld;
        logic [1:0] id;
        logic       last;
        logic       trunc;
        logic       found;
        logic       bsy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        dl_detect_vec = '0;
        token_vec     = '0;
        rpt_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic run_cycle(input logic [3:0] det, input logic [3:0] tok, input logic rdy);
        dl_detect_vec = det;
        token_vec     = tok;
        rpt_ready     = rdy;
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dli"},   dl_detect_in, 0);
        check({tag, "_org"},   origin,       0);
        check({tag, "_tc"},    token_clear,  0);
        check({tag, "_vld"},   rpt_valid,    0);
        check({tag, "_id"},    rpt_proc_id,  0);
        check({tag, "_last"},  rpt_last,     0);
        check({tag, "_trunc"}, rpt_trunc,    0);
        check({tag, "_found"}, dl_found,     0);
        check({tag, "_busy"},  busy,         0);
    endtask

    // Drive origin 1 through the path 2,3 and into REPORT (no checks).
    task automatic path_to_report();
        run_cycle(4'b0110, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0100, 1'b0);
        run_cycle(4'b0000, 4'b0100, 1'b0);
        run_cycle(4'b0000, 4'b1000, 1'b0);
        run_cycle(4'b0000, 4'b0010, 1'b0);
        run_cycle(4'b0010, 4'b0000, 1'b0);
    endtask

    function automatic vec_t mk(input logic [3:0] det, input logic [3:0] tok, input logic rdy,
                                input logic dli, input logic [3:0] org, input logic tc,
                                input logic vld, input logic [1:0] id, input logic last,
                                input logic trunc, input logic found, input logic bsy);
        vec_t v;
        v.det = det; v.tok = tok; v.rdy = rdy; v.dli = dli; v.org = org; v.tc = tc;
        v.vld = vld; v.id = id; v.last = last; v.trunc = trunc; v.found = found; v.bsy = bsy;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   exp_id[3];
        int   ovf_id[4];
        int   hs;
        logic stalled;
        logic [1:0] held_id;
        logic       held_last;

        // Each row: inputs for one cycle and the outputs expected during it.
        //            det      tok      rdy  dli org      tc vld id last tr fnd bsy
        tbl[0]  = mk(4'b0000, 4'b0000, 0,   0, 4'b0000, 0, 0, 0, 0,  0, 0,  0); // reset state
        tbl[1]  = mk(4'b0110, 4'b0000, 0,   0, 4'b0000, 0, 0, 0, 0,  0, 0,  0); // detect sampled
        tbl[2]  = mk(4'b0000, 4'b0000, 0,   1, 4'b0010, 0, 0, 0, 0,  0, 0,  1); // ARM pulse
        tbl[3]  = mk(4'b0000, 4'b0100, 0,   1, 4'b0000, 0, 0, 0, 0,  0, 0,  1); // push 2
        tbl[4]  = mk(4'b0000, 4'b0100, 0,   1, 4'b0000, 0, 0, 0, 0,  0, 0,  1); // repeat 2 ignored
        tbl[5]  = mk(4'b0000, 4'b1000, 0,   1, 4'b0000, 0, 0, 0, 0,  0, 0,  1); // push 3
        tbl[6]  = mk(4'b0000, 4'b0010, 0,   1, 4'b0000, 0, 0, 0, 0,  0, 0,  1); // origin holds token
        tbl[7]  = mk(4'b0010, 4'b0000, 0,   1, 4'b0000, 1, 0, 0, 0,  0, 0,  1); // origin detect -> clear
        tbl[8]  = mk(4'b0000, 4'b0000, 1,   1, 4'b0000, 0, 1, 1, 0,  0, 0,  1); // entry org 1
        tbl[9]  = mk(4'b0000, 4'b0000, 1,   1, 4'b0000, 0, 1, 2, 0,  0, 0,  1); // entry 2
        tbl[10] = mk(4'b0000, 4'b0000, 1,   1, 4'b0000, 0, 1, 3, 1,  0, 0,  1); // entry 3 last
        tbl[11] = mk(4'b0000, 4'b0000, 1,   1, 4'b0000, 0, 0, 0, 0,  0, 1,  1); // DONE

        exp_id = '{1, 2, 3};
        ovf_id = '{1, 0, 2, 3};

        // ---------------- table-driven main path ----------------
        do_reset();
        for (int i = 0; i < 12; i++) begin
            dl_detect_vec = tbl[i].det;
            token_vec     = tbl[i].tok;
            rpt_ready     = tbl[i].rdy;
            #1;
            check($sformatf("row%0d_dli", i),   dl_detect_in, tbl[i].dli);
            check($sformatf("row%0d_org", i),   origin,       tbl[i].org);
            check($sformatf("row%0d_tc", i),    token_clear,  tbl[i].tc);
            check($sformatf("row%0d_vld", i),   rpt_valid,    tbl[i].vld);
            if (tbl[i].vld) begin
                check($sformatf("row%0d_id", i),   rpt_proc_id, tbl[i].id);
                check($sformatf("row%0d_last", i), rpt_last,    tbl[i].last);
            end
            check($sformatf("row%0d_trunc", i), rpt_trunc,    tbl[i].trunc);
            check($sformatf("row%0d_found", i), dl_found,     tbl[i].found);
            check($sformatf("row%0d_busy", i),  busy,         tbl[i].bsy);
            tick();
        end

        // ---------------- backpressure: ready toggles 0/1 ----------------
        do_reset();
        path_to_report();
        hs      = 0;
        stalled = 1'b0;
        held_id = '0;
        held_last = 1'b0;
        for (int c = 0; c < 40 && hs < 3; c++) begin
            dl_detect_vec = '0;
            token_vec     = '0;
            rpt_ready     = (c % 2) == 1;
            #1;
            check("stall_vld", rpt_valid, 1);
            if (stalled) begin
                check("stall_hold_id", rpt_proc_id, held_id);
                check("stall_hold_last", rpt_last, held_last);
            end
            check("stall_id", rpt_proc_id, exp_id[hs]);
            check("stall_last", rpt_last, hs == 2);
            held_id   = rpt_proc_id;
            held_last = rpt_last;
            stalled   = !rpt_ready;
            if (rpt_valid && rpt_ready) hs++;
            tick();
        end
        check("stall_handshakes", hs, 3);
        check("stall_found", dl_found, 1);
        check("stall_done_vld", rpt_valid, 0);

        // ---------------- path overflow -> truncated report ----------------
        do_reset();
        run_cycle(4'b0010, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0001, 1'b0);
        run_cycle(4'b0000, 4'b0100, 1'b0);
        run_cycle(4'b0000, 4'b1000, 1'b0);
        dl_detect_vec = '0;
        token_vec     = 4'b0001;   // fourth push with the buffer full
        #1;
        check("ovf_tc", token_clear, 0);
        tick();
        token_vec = '0;
        for (int k = 0; k < 4; k++) begin
            rpt_ready = 1'b1;
            #1;
            check($sformatf("ovf_vld%0d", k),   rpt_valid,   1);
            check($sformatf("ovf_id%0d", k),    rpt_proc_id, ovf_id[k]);
            check($sformatf("ovf_last%0d", k),  rpt_last,    k == 3);
            check($sformatf("ovf_trunc%0d", k), rpt_trunc,   1);
            check($sformatf("ovf_tc%0d", k),    token_clear, 0);
            tick();
        end
        check("ovf_found", dl_found, 1);
        check("ovf_done_trunc", rpt_trunc, 0);

        // ---------------- empty path: single-entry report ----------------
        do_reset();
        run_cycle(4'b0001, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0000, 1'b0);
        dl_detect_vec = 4'b0001;
        token_vec     = 4'b0001;
        #1;
        check("empty_tc", token_clear, 1);
        tick();
        dl_detect_vec = '0;
        token_vec     = '0;
        rpt_ready     = 1'b1;
        #1;
        check("empty_vld", rpt_valid, 1);
        check("empty_id", rpt_proc_id, 0);
        check("empty_last", rpt_last, 1);
        check("empty_trunc", rpt_trunc, 0);
        tick();
        check("empty_found", dl_found, 1);
        check("empty_done_vld", rpt_valid, 0);
        check("empty_done_dli", dl_detect_in, 1);

        // ---------------- reset mid-REPORT, then clean restart ----------------
        do_reset();
        path_to_report();
        run_cycle(4'b0000, 4'b0000, 1'b1);
        rpt_ready = 1'b0;
        #1;
        check("mid_vld_before", rpt_valid, 1);
        check("mid_id_before", rpt_proc_id, 2);
        reset = 1'b1;
        #1;
        check_idle("rstmid");
        tick();
        reset = 1'b0;
        tick();
        check_idle("rstmid_after");
        dl_detect_vec = 4'b1000;
        #1;
        check("restart_org_early", origin, 0);
        tick();
        dl_detect_vec = '0;
        #1;
        check("restart_org", origin, 4'b1000);
        check("restart_dli", dl_detect_in, 1);
        check("restart_busy", busy, 1);
        tick();
        check("restart_org_pulse", origin, 0);
        check("restart_dli_hold", dl_detect_in, 1);

`ifdef ROCEV2_DL_REPORT_TIMEOUT_EN
        // ---------------- timeout with no token after ARM ----------------
        do_reset();
        run_cycle(4'b0001, 4'b0000, 1'b0);
        run_cycle(4'b0000, 4'b0000, 1'b0);
        for (int w = 1; w <= 7; w++) begin
            #1;
            check($sformatf("to_tc_wait%0d", w), token_clear, 0);
            tick();
        end
        #1;
        check("to_tc_fire", token_clear, 1);
        tick();
        check("to_tc_after", token_clear, 0);
        check("to_dli", dl_detect_in, 0);
        check("to_busy", busy, 0);
        check("to_found", dl_found, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
